// File: rtl/concat_fifo.sv
// Joins one beat from each input channel into a single {in1, in0} word and queues it in a FWFT FIFO.
// Optional CONCAT_FIFO_LEVEL_EN adds level_o (fill count) and almost_full_o outputs.
module concat_fifo #(
    parameter int W0    = 120,
    parameter int W1    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in0_valid_i,
    input  logic [W0-1:0]   in0_data_i,
    output logic            in0_ready_o,
    input  logic            in1_valid_i,
    input  logic [W1-1:0]   in1_data_i,
    output logic            in1_ready_o,
    output logic            out_valid_o,
    output logic [W0+W1-1:0] out_data_o,
    input  logic            out_ready_i
`ifdef CONCAT_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic            almost_full_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = W0 + W1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic full;
    logic empty;
    logic join_fire;
    logic pop_fire;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Full blocks new joins even when a pop is happening this cycle.
    assign join_fire = in0_valid_i & in1_valid_i & ~full;
    assign pop_fire  = ~empty & out_ready_i;

    // Each channel is only ready when its partner is present, so neither is consumed alone.
    assign in0_ready_o = in1_valid_i & ~full & ~rst_i;
    assign in1_ready_o = in0_valid_i & ~full & ~rst_i;

    assign out_valid_o = ~empty;
    assign out_data_o  = empty ? '0 : mem[rd_ptr_reg];

    // Storage has no reset; entries are only visible through the pointers and count.
    always_ff @(posedge clk_i) begin
        if (join_fire) begin
            mem[wr_ptr_reg] <= {in1_data_i, in0_data_i};
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({join_fire, pop_fire})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so natural pointer wrap gives modulo-DEPTH addressing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (join_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

`ifdef CONCAT_FIFO_LEVEL_EN
    assign level_o       = count_reg;
    assign almost_full_o = (count_reg >= CW'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_concat_fifo.sv
// Directed self-checking bench for concat_fifo (default parameters).
// Level/almost-full checks are included only when CONCAT_FIFO_LEVEL_EN is defined.
module tb_concat_fifo;
    localparam int W0 = 120;
    localparam int W1 = 8;
    localparam int DEPTH = 4;
    localparam int DW = W0 + W1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in0_valid_i;
    logic [W0-1:0] in0_data_i;
    logic          in0_ready_o;
    logic          in1_valid_i;
    logic [W1-1:0] in1_data_i;
    logic          in1_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
`ifdef CONCAT_FIFO_LEVEL_EN
    logic [$clog2(DEPTH+1)-1:0] level_o;
    logic          almost_full_o;
`endif

    int checks = 0;
    int passed = 0;

    concat_fifo #(.W0(W0), .W1(W1), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in0_valid_i (in0_valid_i),
        .in0_data_i  (in0_data_i),
        .in0_ready_o (in0_ready_o),
        .in1_valid_i (in1_valid_i),
        .in1_data_i  (in1_data_i),
        .in1_ready_o (in1_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i)
`ifdef CONCAT_FIFO_LEVEL_EN
        ,
        .level_o       (level_o),
        .almost_full_o (almost_full_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W0-1:0] pat0(input int k);
        logic [29:0] s;
        s = 30'(k * 37 + 11);
        return {s, ~s, s, ~s};
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        in0_valid_i = 1'b1; in1_valid_i = 1'b1;
        in0_data_i = '0; in1_data_i = '0; out_ready_i = 1'b0;
        step(); step();
        checks++; if (in0_ready_o !== 1'b0) $display("FAIL reset_in0_ready: got %b expected 0", in0_ready_o); else passed++;
        checks++; if (in1_ready_o !== 1'b0) $display("FAIL reset_in1_ready: got %b expected 0", in1_ready_o); else passed++;
        checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); else passed++;
        checks++; if (out_data_o !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data_o); else passed++;
        in0_valid_i = 1'b0; in1_valid_i = 1'b0;
        rst_i = 1'b0;
        step();
        checks++; if (out_valid_o !== 1'b0) $display("FAIL post_reset_out_valid: got %b expected 0", out_valid_o); else passed++;
    endtask

    task automatic test_single_join();
        logic [W0-1:0] a;
        a = {30{4'hA}};
        in0_data_i = a; in1_data_i = 8'h5C;
        in0_valid_i = 1'b1; in1_valid_i = 1'b1; out_ready_i = 1'b1;
        #1;
        checks++; if (in0_ready_o !== 1'b1) $display("FAIL single_in0_ready: got %b expected 1", in0_ready_o); else passed++;
        checks++; if (in1_ready_o !== 1'b1) $display("FAIL single_in1_ready: got %b expected 1", in1_ready_o); else passed++;
        step();
        in0_valid_i = 1'b0; in1_valid_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", out_valid_o); else passed++;
        checks++; if (out_data_o !== {8'h5C, a}) $display("FAIL single_out_data: got %h expected %h", out_data_o, {8'h5C, a}); else passed++;
        step();
        checks++; if (out_valid_o !== 1'b0) $display("FAIL single_empty_valid: got %b expected 0", out_valid_o); else passed++;
        checks++; if (out_data_o !== '0) $display("FAIL single_empty_data: got %h expected 0", out_data_o); else passed++;
    endtask

    task automatic test_unpaired();
        in0_valid_i = 1'b1; in1_valid_i = 1'b0; out_ready_i = 1'b1;
        in0_data_i = pat0(1);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (in0_ready_o !== 1'b0) $display("FAIL unpaired_in0_ready[%0d]: got %b expected 0", c, in0_ready_o); else passed++;
            checks++; if (out_valid_o !== 1'b0) $display("FAIL unpaired_out_valid[%0d]: got %b expected 0", c, out_valid_o); else passed++;
            step();
        end
        in0_valid_i = 1'b0;
    endtask

    task automatic test_fill_full();
        out_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in0_data_i = pat0(i); in1_data_i = 8'(i);
            in0_valid_i = 1'b1; in1_valid_i = 1'b1;
            #1;
            checks++; if (in0_ready_o !== (i <= 4)) $display("FAIL fill_in0_ready[%0d]: got %b expected %b", i, in0_ready_o, (i <= 4)); else passed++;
            checks++; if (in1_ready_o !== (i <= 4)) $display("FAIL fill_in1_ready[%0d]: got %b expected %b", i, in1_ready_o, (i <= 4)); else passed++;
`ifdef CONCAT_FIFO_LEVEL_EN
            checks++; if (int'(level_o) !== ((i <= 4) ? i - 1 : 4)) $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level_o, (i <= 4) ? i - 1 : 4); else passed++;
            checks++; if (almost_full_o !== (i >= 4)) $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full_o, (i >= 4)); else passed++;
`endif
            step();
        end
        in0_valid_i = 1'b0; in1_valid_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (out_valid_o !== 1'b1) $display("FAIL drain_valid[%0d]: got %b expected 1", i, out_valid_o); else passed++;
            checks++; if (out_data_o !== {8'(i), pat0(i)}) $display("FAIL drain_data[%0d]: got %h expected %h", i, out_data_o, {8'(i), pat0(i)}); else passed++;
            step();
        end
        checks++; if (out_valid_o !== 1'b0) $display("FAIL drain_empty: got %b expected 0", out_valid_o); else passed++;
    endtask

    task automatic test_full_pop();
        out_ready_i = 1'b0;
        in0_valid_i = 1'b1; in1_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in0_data_i = pat0(i + 20); in1_data_i = 8'(i);
            step();
        end
        // Full: pop this cycle but the offered pair (5) must not be taken.
        in0_data_i = pat0(25); in1_data_i = 8'd5; out_ready_i = 1'b1;
        #1;
        checks++; if (in0_ready_o !== 1'b0) $display("FAIL fullpop_in0_ready: got %b expected 0", in0_ready_o); else passed++;
        checks++; if (in1_ready_o !== 1'b0) $display("FAIL fullpop_in1_ready: got %b expected 0", in1_ready_o); else passed++;
        step();
        out_ready_i = 1'b0;
        #1;
`ifdef CONCAT_FIFO_LEVEL_EN
        checks++; if (level_o !== 3'd3) $display("FAIL fullpop_level: got %0d expected 3", level_o); else passed++;
`endif
        checks++; if (in0_ready_o !== 1'b1) $display("FAIL fullpop_rejoin_ready: got %b expected 1", in0_ready_o); else passed++;
        checks++; if (out_data_o !== {8'd2, pat0(22)}) $display("FAIL fullpop_head: got %h expected %h", out_data_o, {8'd2, pat0(22)}); else passed++;
        step();
        in0_valid_i = 1'b0; in1_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            #1;
            checks++; if (out_data_o !== {8'(i), pat0(i + 20)}) $display("FAIL fullpop_drain[%0d]: got %h expected %h", i, out_data_o, {8'(i), pat0(i + 20)}); else passed++;
            step();
        end
        checks++; if (out_valid_o !== 1'b0) $display("FAIL fullpop_empty: got %b expected 0", out_valid_o); else passed++;
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        in0_valid_i = 1'b1; in1_valid_i = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in0_data_i = pat0(k + 100); in1_data_i = 8'(k);
            #1;
            if (k > 0) begin
                checks++; if (out_valid_o !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", k, out_valid_o); else passed++;
                checks++; if (out_data_o !== {8'(k - 1), pat0(k + 99)}) $display("FAIL stream_data[%0d]: got %h expected %h", k, out_data_o, {8'(k - 1), pat0(k + 99)}); else passed++;
                checks++; if (in0_ready_o !== 1'b1) $display("FAIL stream_ready[%0d]: got %b expected 1", k, in0_ready_o); else passed++;
`ifdef CONCAT_FIFO_LEVEL_EN
                checks++; if (level_o !== 3'd1) $display("FAIL stream_level[%0d]: got %0d expected 1", k, level_o); else passed++;
`endif
            end
            step();
        end
        in0_valid_i = 1'b0; in1_valid_i = 1'b0;
        #1;
        checks++; if (out_data_o !== {8'd99, pat0(199)}) $display("FAIL stream_last: got %h expected %h", out_data_o, {8'd99, pat0(199)}); else passed++;
        step();
        checks++; if (out_valid_o !== 1'b0) $display("FAIL stream_empty: got %b expected 0", out_valid_o); else passed++;
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in0_valid_i = 1'b1; in1_valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in0_data_i = pat0(i + 50); in1_data_i = 8'(i + 50);
            step();
        end
        #3;
        rst_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0) $display("FAIL arst_out_valid: got %b expected 0", out_valid_o); else passed++;
        checks++; if (out_data_o !== '0) $display("FAIL arst_out_data: got %h expected 0", out_data_o); else passed++;
        checks++; if (in0_ready_o !== 1'b0) $display("FAIL arst_in0_ready: got %b expected 0", in0_ready_o); else passed++;
        checks++; if (in1_ready_o !== 1'b0) $display("FAIL arst_in1_ready: got %b expected 0", in1_ready_o); else passed++;
`ifdef CONCAT_FIFO_LEVEL_EN
        checks++; if (level_o !== 3'd0) $display("FAIL arst_level: got %0d expected 0", level_o); else passed++;
`endif
        in0_valid_i = 1'b0; in1_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        checks++; if (out_valid_o !== 1'b0) $display("FAIL arst_dropped: got %b expected 0", out_valid_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_join();
        test_unpaired();
        test_fill_full();
        test_full_pop();
        test_streaming();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
